// File: rtl/branch_resolve_unit.sv
// Pipelined branch/jump resolver: one registered stage with valid/ready handshake and flush.
// Optional performance counters are enabled by defining BRANCH_RESOLVE_PERF_EN.
module branch_resolve_unit #(
    parameter int unsigned     XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC_PLUS4 = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_link,
    output logic            out_mispredict,
    output logic            out_illegal
`ifdef BRANCH_RESOLVE_PERF_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
`endif
);

    typedef struct packed {
        logic            taken;
        logic            mispredict;
        logic            illegal;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] link;
    } result_t;

    localparam result_t RESULT_RST = '{
        taken:      1'b0,
        mispredict: 1'b0,
        illegal:    1'b0,
        target:     '0,
        link:       RESET_PC_PLUS4
    };

    logic            eq, lt, ltu;
    logic            cond_met, bad_funct3;
    logic [XLEN-1:0] jalr_sum, jump_target;
    logic            accept;
    result_t         res_new;
    result_t         res_d, res_q;
    logic            valid_d, valid_q;

    assign in_ready = ~valid_q | out_ready;
    assign accept   = in_valid & in_ready & ~flush;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        eq         = (rs1 == rs2);
        lt         = ($signed(rs1) < $signed(rs2));
        ltu        = (rs1 < rs2);
        cond_met   = 1'b0;
        bad_funct3 = 1'b0;
        case (funct3)
            3'b000:  cond_met = eq;
            3'b001:  cond_met = ~eq;
            3'b100:  cond_met = lt;
            3'b101:  cond_met = ~lt;
            3'b110:  cond_met = ltu;
            3'b111:  cond_met = ~ltu;
            default: bad_funct3 = 1'b1;
        endcase

        jalr_sum    = rs1 + imm;
        jump_target = pc + imm;
        res_new     = '0;
        res_new.link = pc + XLEN'(4);

        // JALR outranks JAL, which outranks a conditional branch.
        if (is_jalr) begin
            res_new.taken = 1'b1;
            jump_target   = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (is_jal) begin
            res_new.taken = 1'b1;
        end else if (is_branch) begin
            res_new.taken   = cond_met;
            res_new.illegal = bad_funct3;
        end

        res_new.target     = res_new.taken ? jump_target : res_new.link;
        res_new.mispredict = (res_new.taken != pred_taken)
                           | (res_new.taken & pred_taken & (jump_target != pred_target));
    end

    always_comb begin
        res_d   = res_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            res_d   = res_new;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            res_q   <= RESULT_RST;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_taken      = res_q.taken;
    assign out_target     = res_q.target;
    assign out_link       = res_q.link;
    assign out_mispredict = res_q.mispredict;
    assign out_illegal    = res_q.illegal;

`ifdef BRANCH_RESOLVE_PERF_EN
    logic        ctrl_d, ctrl_q;
    logic        out_fire;
    logic [31:0] branches_d, branches_q;
    logic [31:0] mispredicts_d, mispredicts_q;

    assign out_fire = valid_q & out_ready;

    always_comb begin
        ctrl_d        = ctrl_q;
        branches_d    = branches_q;
        mispredicts_d = mispredicts_q;
        if (accept && !flush) begin
            ctrl_d = is_branch | is_jal | is_jalr;
        end
        // Counters wrap naturally at 32 bits.
        if (out_fire) begin
            branches_d    = branches_q + 32'(ctrl_q);
            mispredicts_d = mispredicts_q + 32'(res_q.mispredict);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q        <= 1'b0;
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            branches_q    <= branches_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    assign perf_branches    = branches_q;
    assign perf_mispredicts = mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed cases, randomized traffic
// against a behavioural model, handshake/flush/reset checks and optional perf counters.
module tb_branch_resolve_unit;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RST_LINK = 32'h0000_0abc;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        is_branch = 1'b0, is_jal = 1'b0, is_jalr = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0, rs2 = '0, pc = '0, imm = '0;
    logic        pred_taken = 1'b0;
    logic [31:0] pred_target = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_taken;
    logic [31:0] out_target, out_link;
    logic        out_mispredict, out_illegal;
`ifdef BRANCH_RESOLVE_PERF_EN
    logic [31:0] perf_branches, perf_mispredicts;
`endif

    branch_resolve_unit #(.XLEN(XLEN), .RESET_PC_PLUS4(RST_LINK)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_target(out_target), .out_link(out_link),
        .out_mispredict(out_mispredict), .out_illegal(out_illegal)
`ifdef BRANCH_RESOLVE_PERF_EN
        , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          taken;
        bit          mis;
        bit          ill;
        bit          ctrl;
        logic [31:0] target;
        logic [31:0] link;
    } exp_t;

    exp_t        exp_q;
    bit          exp_valid = 1'b0;
    int unsigned exp_br = 0, exp_mp = 0;
    int          passed = 0, total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Reference: what an RV32I core is architecturally required to do with this instruction.
    function automatic exp_t ref_resolve();
        exp_t        r;
        bit          cond;
        bit          legal;
        logic [31:0] dest;
        r     = '{default: 0};
        legal = 1'b1;
        case (funct3)
            3'd0:    cond = (rs1 == rs2);
            3'd1:    cond = (rs1 != rs2);
            3'd4:    cond = (int'(rs1) < int'(rs2));
            3'd5:    cond = (int'(rs1) >= int'(rs2));
            3'd6:    cond = (rs1 < rs2);
            3'd7:    cond = (rs1 >= rs2);
            default: begin cond = 1'b0; legal = 1'b0; end
        endcase
        dest   = pc + imm;
        r.ctrl = is_branch || is_jal || is_jalr;
        if (is_jalr)        begin r.taken = 1'b1; dest = (rs1 + imm) & 32'hffff_fffe; end
        else if (is_jal)    r.taken = 1'b1;
        else if (is_branch) begin r.taken = cond; r.ill = !legal; end
        r.link   = pc + 32'd4;
        r.target = r.taken ? dest : r.link;
        r.mis    = r.taken ? !(pred_taken && pred_target == dest) : pred_taken;
        return r;
    endfunction

    task automatic check_outputs();
        chk("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            chk("out_taken", out_taken, exp_q.taken);
            chk("out_target", out_target, exp_q.target);
            chk("out_link", out_link, exp_q.link);
            chk("out_mispredict", out_mispredict, exp_q.mis);
            chk("out_illegal", out_illegal, exp_q.ill);
        end
`ifdef BRANCH_RESOLVE_PERF_EN
        chk("perf_branches", perf_branches, exp_br);
        chk("perf_mispredicts", perf_mispredicts, exp_mp);
`endif
    endtask

    // One clock: check in_ready, advance the model, take the edge, check outputs.
    task automatic step();
        bit   acc;
        exp_t nxt;
        #1;
        chk("in_ready", in_ready, !exp_valid || out_ready);
        acc = in_valid && (!exp_valid || out_ready) && !flush;
        nxt = ref_resolve();
        if (exp_valid && out_ready) begin
            if (exp_q.ctrl) exp_br++;
            if (exp_q.mis)  exp_mp++;
        end
        if (flush)          exp_valid = 1'b0;
        else if (acc)       begin exp_valid = 1'b1; exp_q = nxt; end
        else if (out_ready) exp_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic set_in(input bit b, input bit j, input bit jr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] c, input logic [31:0] p,
                          input logic [31:0] i, input bit pt, input logic [31:0] ptg);
        in_valid = 1'b1; is_branch = b; is_jal = j; is_jalr = jr; funct3 = f3;
        rs1 = a; rs2 = c; pc = p; imm = i; pred_taken = pt; pred_target = ptg;
    endtask

    // Asynchronous reset asserted away from any clock edge.
    task automatic reset_mid();
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        exp_valid = 1'b0; exp_br = 0; exp_mp = 0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_link", out_link, RST_LINK);
        chk("rst_out_target", out_target, 32'h0);
        chk("rst_out_taken", out_taken, 1'b0);
        chk("rst_out_mispredict", out_mispredict, 1'b0);
        chk("rst_out_illegal", out_illegal, 1'b0);
`ifdef BRANCH_RESOLVE_PERF_EN
        chk("rst_perf_branches", perf_branches, 32'h0);
        chk("rst_perf_mispredicts", perf_mispredicts, 32'h0);
`endif
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        reset_mid();
        out_ready = 1'b1;

        // BLT: -1 < 1 signed, predicted not taken.
        set_in(1, 0, 0, 3'b100, 32'hffff_ffff, 32'h1, 32'h100, 32'h20, 0, 32'h0);
        step();
        chk("blt_taken", out_taken, 1'b1);
        chk("blt_target", out_target, 32'h120);
        chk("blt_mis", out_mispredict, 1'b1);

        // BLTU: 0xFFFFFFFF is not below 1 unsigned.
        set_in(1, 0, 0, 3'b110, 32'hffff_ffff, 32'h1, 32'h100, 32'h20, 0, 32'h0);
        step();
        chk("bltu_taken", out_taken, 1'b0);
        chk("bltu_target", out_target, 32'h104);
        chk("bltu_mis", out_mispredict, 1'b0);

        // JALR clears bit 0 of rs1+imm.
        set_in(0, 0, 1, 3'b000, 32'h2003, 32'h0, 32'h300, 32'h0, 1, 32'h2002);
        step();
        chk("jalr_target", out_target, 32'h2002);
        chk("jalr_link", out_link, 32'h304);
        chk("jalr_mis", out_mispredict, 1'b0);

        // Backpressure: a new input is offered while the consumer stalls.
        out_ready = 1'b0;
        set_in(1, 0, 0, 3'b000, 32'h7, 32'h7, 32'h500, 32'h40, 1, 32'h540);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_hold_target", out_target, 32'h2002);
        end
        out_ready = 1'b1;
        step();
        chk("bp_new_target", out_target, 32'h540);
        chk("bp_new_valid", out_valid, 1'b1);

        // Flush dominates a simultaneous accept.
        flush = 1'b1;
        set_in(0, 1, 0, 3'b000, 32'h0, 32'h0, 32'h600, 32'h8, 0, 32'h0);
        step();
        chk("flush_valid", out_valid, 1'b0);
        flush = 1'b0;

        // Reserved funct3 on a branch.
        set_in(1, 0, 0, 3'b010, 32'h1, 32'h1, 32'h700, 32'h10, 1, 32'h710);
        step();
        chk("ill_flag", out_illegal, 1'b1);
        chk("ill_taken", out_taken, 1'b0);
        chk("ill_mis", out_mispredict, 1'b1);

        // Target wraps modulo 2^32.
        set_in(1, 0, 0, 3'b000, 32'h5, 32'h5, 32'hffff_fffc, 32'h8, 1, 32'h4);
        step();
        chk("wrap_target", out_target, 32'h4);
        chk("wrap_mis", out_mispredict, 1'b0);

        // Randomized traffic including overlapping decode flags and non-control instructions.
        for (int n = 0; n < 400; n++) begin
            logic [2:0]  fl;
            logic [31:0] a, c, p, i;
            fl = 3'($urandom_range(0, 7));
            a  = $urandom;
            c  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            p  = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            i  = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
            set_in(fl[0], fl[1], fl[2], 3'($urandom_range(0, 7)), a, c, p, i,
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) == 0) ? p + i : $urandom);
            in_valid  = ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            step();
        end
        flush = 1'b0;

        // Clean start, then five handshaked control instructions, two mispredicted.
        reset_mid();
        out_ready = 1'b1;
        set_in(1, 0, 0, 3'b000, 32'h3, 32'h3, 32'h400, 32'h10, 1, 32'h410); step();
        set_in(1, 0, 0, 3'b001, 32'h3, 32'h3, 32'h400, 32'h10, 0, 32'h0);   step();
        set_in(0, 1, 0, 3'b000, 32'h0, 32'h0, 32'h400, 32'h10, 0, 32'h0);   step();
        set_in(1, 0, 0, 3'b100, 32'h1, 32'h2, 32'h400, 32'h10, 1, 32'h999); step();
        set_in(1, 0, 0, 3'b111, 32'h5, 32'h3, 32'h400, 32'h10, 1, 32'h410); step();
        in_valid = 1'b0;
        step();
        chk("drain_valid", out_valid, 1'b0);
`ifdef BRANCH_RESOLVE_PERF_EN
        chk("perf5_branches", perf_branches, 32'd5);
        chk("perf5_mispredicts", perf_mispredicts, 32'd2);
`endif

        // Reset with a result held under backpressure.
        out_ready = 1'b0;
        set_in(0, 1, 0, 3'b000, 32'h0, 32'h0, 32'h800, 32'h20, 0, 32'h0);
        step();
        chk("pre_reset_valid", out_valid, 1'b1);
        in_valid = 1'b0;
        reset_mid();
        out_ready = 1'b1;
        set_in(0, 1, 0, 3'b000, 32'h0, 32'h0, 32'h900, 32'h20, 1, 32'h920);
        step();
        chk("post_reset_target", out_target, 32'h920);
        in_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
